// File: rtl/period_meter_pkg.sv
// period_meter_pkg: state encoding and default parameters shared by the period meter files.
package period_meter_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, STALLED} pm_state_t;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_TIMEOUT = 100_000_000;
  localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/period_meter_sync_rise_detect.sv
// sync_rise_detect: multi-flop synchronizer for an asynchronous input plus rising-edge pulse.
module sync_rise_detect import period_meter_pkg::*; #(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic lvl,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prv_q, prv_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prv_d = sync_q[SYNC_STAGES-1];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prv_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prv_q <= prv_d;
    end
  end
  assign lvl = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~prv_q;
endmodule

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow signal in clk cycles,
// delivering results over valid/ready with sticky overrun and a stall flag.
module period_meter import period_meter_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             result_ready,
  input  logic             clr_overrun,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             result_valid,
  output logic             overrun,
  output logic             stalled
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  pm_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, period_q, period_d, high_q, high_d;
  logic valid_q, valid_d, overrun_q, overrun_d, stalled_q, stalled_d;
  logic lvl, rise, latch;
  sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset(reset),
    .d(sig_in),
    .lvl(lvl),
    .rise(rise)
  );
  // Only a rise that closes a full period produces a result; IDLE/STALLED rises just restart counting.
  always_comb begin
    latch = rise && (state_q == MEASURE);
    state_d = state_q;
    cnt_d = cnt_q;
    hcnt_d = hcnt_q;
    stalled_d = stalled_q;
    if (rise) begin
      state_d = MEASURE;
      cnt_d = ONE;
      hcnt_d = ONE;
      stalled_d = 1'b0;
    end else if (state_q == MEASURE) begin
      cnt_d = cnt_q + ONE;
      hcnt_d = hcnt_q + CNT_W'(lvl);
      if (cnt_q == LAST) begin
        state_d = STALLED;
        stalled_d = 1'b1;
      end
    end
    period_d = latch ? cnt_q : period_q;
    high_d = latch ? hcnt_q : high_q;
    valid_d = latch | (valid_q & ~result_ready);
    overrun_d = (latch & valid_q & ~result_ready) | (overrun_q & ~clr_overrun);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hcnt_q <= '0;
      period_q <= '0;
      high_q <= '0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hcnt_q <= hcnt_d;
      period_q <= period_d;
      high_q <= high_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
      stalled_q <= stalled_d;
    end
  end
  assign period = period_q;
  assign high_time = high_q;
  assign result_valid = valid_q;
  assign overrun = overrun_q;
  assign stalled = stalled_q;
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed tables, hand sequences and random waveforms checked
// against a timestamp-based reference model of the period meter.
module tb_period_meter;
  localparam int TO = 64;
  logic clk = 0, reset = 0, sig_in = 0, result_ready = 0, clr_overrun = 0;
  logic [31:0] period, high_time;
  logic result_valid, overrun, stalled;
  int checks = 0, errors = 0;

  period_meter #(.CNT_W(32), .TIMEOUT(TO), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .result_ready(result_ready),
    .clr_overrun(clr_overrun), .period(period), .high_time(high_time),
    .result_valid(result_valid), .overrun(overrun), .stalled(stalled)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the sample stream seen two clocks late, with rises timestamped.
  bit samp[$];
  int mk, last_r, highs, nper, nhigh;
  bit ms, mp, mlatch, mset, armed, m_valid, m_over, m_stall;
  longint m_period, m_high;
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      samp.delete();
      armed = 0; m_stall = 0; m_valid = 0; m_over = 0; m_period = 0; m_high = 0;
    end else begin
      mk = samp.size();
      ms = mk >= 2 ? samp[mk-2] : 1'b0;
      mp = mk >= 3 ? samp[mk-3] : 1'b0;
      samp.push_back(sig_in);
      mlatch = 0;
      if (ms && !mp) begin
        if (armed && !m_stall) begin
          mlatch = 1; nper = mk - last_r; nhigh = highs;
        end
        armed = 1; m_stall = 0; last_r = mk; highs = 1;
      end else if (armed && !m_stall) begin
        highs += ms;
        if (mk - last_r == TO - 1) m_stall = 1;
      end
      mset = mlatch && m_valid && !result_ready;
      if (mlatch) m_valid = 1;
      else if (m_valid && result_ready) m_valid = 0;
      if (mset) m_over = 1;
      else if (clr_overrun) m_over = 0;
      if (mlatch) begin m_period = nper; m_high = nhigh; end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    check("model period", period, m_period);
    check("model high_time", high_time, m_high);
    check("model result_valid", result_valid, m_valid);
    check("model overrun", overrun, m_over);
    check("model stalled", stalled, m_stall);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 0; sig_in = 0; result_ready = 1; clr_overrun = 0;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic pulse(input int h, input int l);
    repeat (h) begin @(negedge clk); sig_in = 1; end
    repeat (l) begin @(negedge clk); sig_in = 0; end
  endtask

  task automatic rnd_cyc(input logic s);
    @(negedge clk);
    sig_in = s;
    result_ready = ($urandom_range(3, 0) != 0);
    clr_overrun = ($urandom_range(9, 0) == 0);
  endtask

  typedef struct { int p; int h; int ep; int eh; int eov; } vec_t;
  vec_t tbl[7];
  int nres, nrise, p, h, n, gap;
  bit got;

  initial begin
    tbl = '{'{10, 3, 10, 3, 0}, '{2, 1, 2, 1, 0}, '{8, 4, 8, 4, 0}, '{5, 1, 5, 1, 0},
            '{16, 15, 16, 15, 0}, '{7, 6, 7, 6, 0}, '{3, 2, 3, 2, 0}};
    do_reset();
    #1;
    check("reset period", period, 0);
    check("reset high_time", high_time, 0);
    check("reset result_valid", result_valid, 0);
    check("reset overrun", overrun, 0);
    check("reset stalled", stalled, 0);

    // divided_clocks[2] source
    do_reset();
    nres = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (result_valid) begin
        nres++;
        check("div2 period", period, 8);
        check("div2 high_time", high_time, 4);
      end
      sig_in = i[2];
    end
    check("div2 result count", nres, 6);
    check("div2 overrun", overrun, 0);

    do_reset();
    foreach (tbl[j]) begin
      repeat (4) pulse(tbl[j].h, tbl[j].p - tbl[j].h);
      repeat (4) @(negedge clk);
      check($sformatf("tbl%0d period", j), period, tbl[j].ep);
      check($sformatf("tbl%0d high_time", j), high_time, tbl[j].eh);
      check($sformatf("tbl%0d overrun", j), overrun, tbl[j].eov);
    end

    // stall after TIMEOUT, then recovery needing two rises
    do_reset();
    repeat (3) pulse(4, 4);
    @(negedge clk); sig_in = 1;
    for (int s = 1; s <= 66; s++) begin
      @(negedge clk);
      if (s == 65) check("stall not yet", stalled, 0);
      if (s == 66) begin
        check("stall set", stalled, 1);
        check("stall valid held", result_valid, 0);
        check("stall period held", period, 8);
        check("stall high held", high_time, 4);
      end
      if (s == 4) sig_in = 0;
    end
    @(negedge clk); sig_in = 1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("resume stalled cleared", stalled, 0);
    check("resume no result", result_valid, 0);
    sig_in = 0;
    repeat (6) @(negedge clk);
    @(negedge clk); sig_in = 1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("resume valid", result_valid, 1);
    check("resume period", period, 10);
    check("resume high_time", high_time, 3);
    sig_in = 0;

    // overrun from two unaccepted results, clear, then accept
    do_reset();
    result_ready = 0;
    pulse(4, 4); pulse(6, 6); pulse(1, 5);
    check("ovr period", period, 12);
    check("ovr high_time", high_time, 6);
    check("ovr valid", result_valid, 1);
    check("ovr flag", overrun, 1);
    @(negedge clk); clr_overrun = 1;
    @(negedge clk); clr_overrun = 0;
    check("ovr cleared", overrun, 0);
    check("ovr valid kept", result_valid, 1);
    @(negedge clk); result_ready = 1;
    @(negedge clk); result_ready = 0;
    check("ovr accepted", result_valid, 0);

    // accept in the same cycle as a new latch
    do_reset();
    result_ready = 0;
    pulse(4, 4); pulse(5, 5);
    @(negedge clk); sig_in = 1;
    @(negedge clk);
    @(negedge clk);
    check("same-cycle old period", period, 8);
    result_ready = 1;
    @(negedge clk);
    result_ready = 0;
    check("same-cycle valid", result_valid, 1);
    check("same-cycle period", period, 10);
    check("same-cycle high_time", high_time, 5);
    check("same-cycle overrun", overrun, 0);
    pulse(0, 3);

    // asynchronous reset mid-measurement
    do_reset();
    for (int i = 0; i < 31; i++) begin @(negedge clk); sig_in = i[2]; end
    @(negedge clk);
    check("pre-reset period", period, 8);
    sig_in = 1;
    reset = 0;
    #1;
    check("async period", period, 0);
    check("async high_time", high_time, 0);
    check("async valid", result_valid, 0);
    check("async overrun", overrun, 0);
    check("async stalled", stalled, 0);
    got = 0; nrise = 0;
    for (int i = 32; i < 100; i++) begin
      @(negedge clk);
      if (result_valid && !got) begin
        got = 1;
        check("post-reset rises before result", nrise, 2);
        check("post-reset period", period, 8);
        check("post-reset high_time", high_time, 4);
      end
      if (i == 34) reset = 1;
      if (i[2] && !sig_in) nrise++;
      sig_in = i[2];
    end
    check("post-reset result seen", got, 1);

    // random waveforms, ready and clear against the model
    do_reset();
    for (int b = 0; b < 80; b++) begin
      p = $urandom_range(20, 2);
      h = $urandom_range(p - 1, 1);
      n = $urandom_range(4, 1);
      if ($urandom_range(5, 0) == 0) begin
        gap = $urandom_range(80, 55);
        repeat (gap) rnd_cyc(1'b0);
      end
      repeat (n) for (int c = 0; c < p; c++) rnd_cyc(c < h);
    end
    @(negedge clk);
    clr_overrun = 0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures a slow periodic signal, such as a clock_divider output tap or an external square wave, against the system clock.
- Reports two values, both in system clock cycles:
  - period: rising edge to rising edge.
  - high time: cycles the signal was high within that period.
- Sits downstream of the divider to check frequency and duty cycle on HEX and LED outputs.
- Results are delivered through a valid/ready handshake, with stall and overrun flags.

Parameters:
- CNT_W, 32: width of the period, high-time and internal counters.
- TIMEOUT, 100_000_000: cycles without a rising edge before stall is declared. Must be < 2**CNT_W.
- SYNC_STAGES, 2: number of synchronizer flops on sig_in. Must be >= 2.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- reset  input  1  asynchronous, active-low reset; 0 clears all state.
- sig_in  input  1  measured signal; may be asynchronous to clk.
- result_ready  input  1  consumer accepts the result when result_valid && result_ready.
- clr_overrun  input  1  single-cycle pulse that clears the overrun flag.
- period  output  CNT_W  last latched period, in cycles.
- high_time  output  CNT_W  last latched high time, in cycles.
- result_valid  output  1  a result is held and has not yet been accepted.
- overrun  output  1  sticky: an unaccepted result was overwritten.
- stalled  output  1  no rising edge seen for TIMEOUT cycles.

Behaviour:
- Reset (reset=0): period=0, high_time=0, result_valid=0, overrun=0, stalled=0. Synchronizer and previous-level flops = 0; internal counters = 0; state = IDLE. Reset is effective immediately, including mid-measurement.
- Synchronizer and edge detect:
  - sig_in passes through SYNC_STAGES flops to give lvl; prv = lvl delayed by one cycle.
  - rise = lvl & ~prv.
  - If sig_in is high at reset release, a rise is produced after the sync latency. This is harmless because IDLE only starts a measurement.
- State machine (IDLE, MEASURE, STALLED):
  - IDLE, rise: cnt<=1, hcnt<=1, go to MEASURE. No result is produced.
  - MEASURE, no rise:
    - cnt<=cnt+1.
    - hcnt<=hcnt+lvl.
    - If cnt==TIMEOUT-1, go to STALLED and set stalled<=1.
  - MEASURE, rise:
    - period<=cnt, high_time<=hcnt.
    - cnt<=1, hcnt<=1.
    - result update per the handshake rules below.
  - STALLED, rise: stalled<=0, cnt<=1, hcnt<=1, go to MEASURE. The partial period is discarded; the next result needs a full period.
- Counter convention: a signal with P-cycle period and H-cycle high time yields period=P and high_time=H. Examples: divided_clocks[k] gives P=2**(k+1), H=2**k; divided_clocks[0] gives P=2, H=1.
- Latency: result_valid rises SYNC_STAGES+1 clk edges after the first edge that samples sig_in high at the end of a period.
- Handshake:
  - Accept = result_valid && result_ready. On accept with no new latch, result_valid<=0.
  - While result_valid=1 and not accepted, period and high_time are held stable.
  - New latch while result_valid && !result_ready: data overwritten, result_valid stays 1, overrun<=1.
  - New latch in the same cycle as accept: new data loaded, result_valid stays 1, overrun unchanged.
- overrun clear:
  - Cleared only by clr_overrun=1 (or by reset).
  - If clr_overrun and a new overrun occur in the same cycle, set wins: overrun=1.
- Stall does not affect result_valid or the held data.
- No counter wraps, because TIMEOUT < 2**CNT_W bounds cnt.

Decomposition:
- Package period_meter_pkg holds:
  - typedef enum logic [1:0] {IDLE, MEASURE, STALLED} pm_state_t.
  - Default constants: CNT_W, TIMEOUT, SYNC_STAGES.
- Sub-module sync_rise_detect (clk, reset, d, lvl, rise), parameterised by SYNC_STAGES. It is reusable for KEY and SW inputs.

Test Plan:
1. sig_in = clock_divider divided_clocks[2], result_ready=1 -> first rise produces no result; then result_valid pulses every 8 cycles with period=8, high_time=4; overrun=0.
2. Hand-driven sig_in, 3 cycles high / 7 low, result_ready=1 -> period=10, high_time=3 on every result.
3. TIMEOUT=64, sig_in held low after a rise -> stalled=1 exactly 64 cycles after that rise, held data and result_valid unchanged. Pulses resume -> stalled=0 on first rise; next result only after the second rise.
4. result_ready=0 across two completed periods (P=8, then P=12) -> period=12, result_valid=1, overrun=1. Pulse clr_overrun -> overrun=0; result_ready=1 for one cycle -> result_valid=0.
5. result_ready=1 in exactly the cycle of a new latch -> result_valid stays 1, new data visible next cycle, overrun=0.
6. reset=0 mid-MEASURE with sig_in high -> all outputs 0 asynchronously. Release -> no result until two rising edges have passed; first result is correct (P=8, H=4 with the divided_clocks[2] source).
